// File: rtl/mem_definitions.sv
// Shared memory-access types for the data-memory path: access size/sign
// encoding and the data-memory controller state encoding.
package mem_definitions;

   typedef enum logic [2:0] {
      BYTE  = 3'd0,
      HALF  = 3'd1,
      WORD  = 3'd2,
      UBYTE = 3'd3,
      UHALF = 3'd4
   } mem_mask_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

endpackage

// File: rtl/dmem_lane_gen.sv
// Byte-lane generation for a data-memory access: byte enables, lane-replicated
// store data and alignment check, all from the access size and address low bits.
module dmem_lane_gen
   import mem_definitions::*;
(
   input  mem_mask_t   mem_type,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic        misaligned
);

   // Unknown encodings enable no lanes and are never flagged as misaligned.
   always_comb begin
      be         = 4'b0000;
      wdata_rep  = wdata;
      misaligned = 1'b0;
      case (mem_type)
         BYTE, UBYTE: begin
            be        = 4'b0001 << addr;
            wdata_rep = {4{wdata[7:0]}};
         end
         HALF, UHALF: begin
            be         = addr[1] ? 4'b1100 : 4'b0011;
            wdata_rep  = {2{wdata[15:0]}};
            misaligned = addr[0];
         end
         WORD: begin
            be         = 4'b1111;
            misaligned = (addr != 2'b00);
         end
         default: begin
            be         = 4'b0000;
            wdata_rep  = wdata;
            misaligned = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns memory-stage load/store requests into a
// single-outstanding bus transaction, stalling the pipeline until completion.
module dmem_ctrl
   import mem_definitions::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m_MemRead,
   input  logic        m_MemWrite,
   input  mem_mask_t   m_mem_type,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_wdata,
   output logic        stall_mem,
   output logic [31:0] read_data,
   output logic        misalign,
   output logic        bus_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   dmem_state_t state;
   logic [31:0] cnt;
   logic [3:0]  be_s;
   logic [31:0] wdata_s;
   logic        misaligned_s;
   logic        req_s;

   dmem_lane_gen u_lane_gen (
      .mem_type   (m_mem_type),
      .addr       (m_addr[1:0]),
      .wdata      (m_wdata),
      .be         (be_s),
      .wdata_rep  (wdata_s),
      .misaligned (misaligned_s)
   );

   assign req_s = m_MemRead | m_MemWrite;

   // rst_n is active-high here: the stall must drop while reset is held.
   assign stall_mem = !rst_n &&
                      (((state == IDLE) && req_s && !misaligned_s) || (state == BUS));

   // Transaction FSM with registered bus side, status pulses and read data.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= IDLE;
         cnt       <= 32'd0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 32'd0;
         bus_be    <= 4'b0000;
         bus_wdata <= 32'd0;
         read_data <= 32'd0;
         misalign  <= 1'b0;
         bus_err   <= 1'b0;
      end else begin
         misalign <= 1'b0;
         bus_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_s && !misaligned_s) begin
                  state     <= BUS;
                  cnt       <= 32'd0;
                  bus_req   <= 1'b1;
                  bus_we    <= m_MemWrite;
                  bus_addr  <= {m_addr[31:2], 2'b00};
                  bus_be    <= be_s;
                  bus_wdata <= wdata_s;
               end else if (req_s) begin
                  misalign  <= 1'b1;
                  read_data <= 32'd0;
               end
            end
            BUS: begin
               if (bus_ack) begin
                  if (!bus_we) begin
                     read_data <= bus_rdata;
                  end
                  state   <= DONE;
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
               end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                  bus_err   <= 1'b1;
                  read_data <= 32'd0;
                  state     <= DONE;
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               bus_req <= 1'b0;
               bus_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule
